// File: rtl/tug_field_engine.sv
// -----------------------------------------------------------------------------
// tug_field_engine
// Tug-of-war playfield engine. A single lit position on an N-light field is
// pulled left or right by rising edges on the player inputs. The right player
// may be replaced by an LFSR-driven computer opponent. Each player has a
// score counter, and the match ends when either score reaches WIN_SCORE.
//
// Parameters
//   NUM_LIGHTS  playfield width, legal range 3..32
//   SCORE_W     width of each score counter
//   WIN_SCORE   points that end the match, 1 .. 2^SCORE_W-1
//   LFSR_W      computer-player LFSR width
//   TAP_MASK    LFSR feedback taps (XNOR feedback, all-ones is the lock-up state)
//
// Ports
//   clk         system clock, all state updates on posedge
//   reset       synchronous active-high reset
//   in_l        left player level input (already synchronised)
//   in_r        right player level input (ignored when cpu_en=1)
//   cpu_en      1 = right player driven by the LFSR computer
//   cpu_thresh  computer aggressiveness, larger means more presses
//   field       one-hot light position, MSB = leftmost
//   score_l/r   player scores
//   point_l/r   one-cycle pulse when a player scores
//   match_over  high once either score reaches WIN_SCORE
//   winner      0 = left won, 1 = right won (valid while match_over=1)
// -----------------------------------------------------------------------------
module tug_field_engine #(
  parameter int unsigned              NUM_LIGHTS = 9,
  parameter int unsigned              SCORE_W    = 3,
  parameter int unsigned              WIN_SCORE  = 7,
  parameter int unsigned              LFSR_W     = 10,
  parameter logic [LFSR_W-1:0]        TAP_MASK   = 10'b1001000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_l,
  input  logic                  in_r,
  input  logic                  cpu_en,
  input  logic [LFSR_W-1:0]     cpu_thresh,
  output logic [NUM_LIGHTS-1:0] field,
  output logic [SCORE_W-1:0]    score_l,
  output logic [SCORE_W-1:0]    score_r,
  output logic                  point_l,
  output logic                  point_r,
  output logic                  match_over,
  output logic                  winner
);

  localparam int unsigned CENTER = NUM_LIGHTS / 2;
  localparam logic [NUM_LIGHTS-1:0] FIELD_CENTER =
    NUM_LIGHTS'(1) << CENTER;
  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_POINT = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_LIGHTS-1:0]   field_q, field_d;
  logic [SCORE_W-1:0]      score_l_q, score_l_d;
  logic [SCORE_W-1:0]      score_r_q, score_r_d;
  logic                    point_l_q, point_l_d;
  logic                    point_r_q, point_r_d;
  logic                    match_over_q, match_over_d;
  logic                    winner_q, winner_d;
  logic [LFSR_W-1:0]       lfsr_q, lfsr_d;
  logic                    in_l_q, in_r_q;

  logic                    cpu_req;
  logic                    req_r;
  logic                    press_l;
  logic                    press_r;

  // Computer opponent: XNOR-feedback LFSR compared against the threshold.
  assign lfsr_d  = {lfsr_q[LFSR_W-2:0], ~^(lfsr_q & TAP_MASK)};
  assign cpu_req = (cpu_thresh > lfsr_q);
  assign req_r   = cpu_en ? cpu_req : in_r;

  // Rising-edge press detection; a held level yields a single press.
  assign press_l = in_l  & ~in_l_q;
  assign press_r = req_r & ~in_r_q;

  // Edge registers and LFSR run in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_l_q <= 1'b0;
      in_r_q <= 1'b0;
      lfsr_q <= '0;
    end else begin
      in_l_q <= in_l;
      in_r_q <= req_r;
      lfsr_q <= lfsr_d;
    end
  end

  // Match state register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_PLAY;
      field_q      <= FIELD_CENTER;
      score_l_q    <= '0;
      score_r_q    <= '0;
      point_l_q    <= 1'b0;
      point_r_q    <= 1'b0;
      match_over_q <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      field_q      <= field_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      point_l_q    <= point_l_d;
      point_r_q    <= point_r_d;
      match_over_q <= match_over_d;
      winner_q     <= winner_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    field_d      = field_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    point_l_d    = 1'b0;
    point_r_d    = 1'b0;
    match_over_d = match_over_q;
    winner_d     = winner_q;

    unique case (state_q)
      ST_PLAY: begin
        // Simultaneous presses cancel each other out.
        if (press_l && !press_r) begin
          if (field_q[NUM_LIGHTS-1]) begin
            state_d   = ST_POINT;
            field_d   = '0;
            point_l_d = 1'b1;
            score_l_d = score_l_q + SCORE_W'(1);
          end else begin
            field_d = field_q << 1;
          end
        end else if (press_r && !press_l) begin
          if (field_q[0]) begin
            state_d   = ST_POINT;
            field_d   = '0;
            point_r_d = 1'b1;
            score_r_d = score_r_q + SCORE_W'(1);
          end else begin
            field_d = field_q >> 1;
          end
        end
      end

      ST_POINT: begin
        // Presses here are dropped; the scorer is identified by its pulse.
        if (point_l_q && (score_l_q == WIN_VAL)) begin
          state_d      = ST_OVER;
          match_over_d = 1'b1;
          winner_d     = 1'b0;
        end else if (point_r_q && (score_r_q == WIN_VAL)) begin
          state_d      = ST_OVER;
          match_over_d = 1'b1;
          winner_d     = 1'b1;
        end else begin
          state_d = ST_PLAY;
          field_d = FIELD_CENTER;
        end
      end

      ST_OVER: begin
        state_d = ST_OVER;
      end

      default: begin
        state_d = ST_PLAY;
        field_d = FIELD_CENTER;
      end
    endcase
  end

  assign field      = field_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign point_l    = point_l_q;
  assign point_r    = point_r_q;
  assign match_over = match_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_tug_field_engine.sv
// -----------------------------------------------------------------------------
// tb_tug_field_engine
// Self-checking bench for tug_field_engine with default parameters. A
// behavioural model tracks the light as an integer position plus a dark flag,
// scores as integers and the LFSR as an integer, advanced once per clock edge.
// -----------------------------------------------------------------------------
module tb_tug_field_engine;

  localparam int N   = 9;
  localparam int SW  = 3;
  localparam int WIN = 7;
  localparam int LW  = 10;
  localparam int TAP = 10'b1001000000;
  localparam int C   = N / 2;
  localparam logic [N-1:0] CENTER_F = 9'b000010000;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_l;
  logic          in_r;
  logic          cpu_en;
  logic [LW-1:0] cpu_thresh;
  logic [N-1:0]  field;
  logic [SW-1:0] score_l;
  logic [SW-1:0] score_r;
  logic          point_l;
  logic          point_r;
  logic          match_over;
  logic          winner;

  int checks   = 0;
  int failures = 0;

  tug_field_engine dut (
    .clk        (clk),
    .reset      (reset),
    .in_l       (in_l),
    .in_r       (in_r),
    .cpu_en     (cpu_en),
    .cpu_thresh (cpu_thresh),
    .field      (field),
    .score_l    (score_l),
    .score_r    (score_r),
    .point_l    (point_l),
    .point_r    (point_r),
    .match_over (match_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  int m_pos;
  bit m_dark;
  bit m_pl;
  bit m_pr;
  bit m_over;
  bit m_win;
  int m_sl;
  int m_sr;
  bit m_prev_l;
  bit m_prev_r;
  int m_lfsr;

  function automatic logic [N-1:0] m_field();
    if (m_dark || m_over) return '0;
    return N'(1) << m_pos;
  endfunction

  function automatic logic [18:0] m_vec();
    return {m_field(), SW'(m_sl), SW'(m_sr), m_pl, m_pr, m_over, m_win};
  endfunction

  // Apply one clock edge's worth of game rules to the model.
  task automatic model_step();
    bit pl;
    bit pr;
    bit req;
    if (reset) begin
      m_pos = C; m_dark = 0; m_pl = 0; m_pr = 0; m_over = 0; m_win = 0;
      m_sl = 0; m_sr = 0; m_prev_l = 0; m_prev_r = 0; m_lfsr = 0;
      return;
    end
    req = cpu_en ? (int'(cpu_thresh) > m_lfsr) : in_r;
    pl  = in_l && !m_prev_l;
    pr  = req && !m_prev_r;
    m_prev_l = in_l;
    m_prev_r = req;
    m_lfsr = ((m_lfsr << 1) | ((($countones(m_lfsr & TAP) % 2) == 0) ? 1 : 0)) & 1023;
    if (m_over) return;
    if (m_pl || m_pr) begin
      if ((m_pl && m_sl == WIN) || (m_pr && m_sr == WIN)) begin
        m_over = 1;
        m_win  = m_pr;
      end else begin
        m_dark = 0;
        m_pos  = C;
      end
      m_pl = 0;
      m_pr = 0;
      return;
    end
    if (pl && !pr) begin
      if (m_pos == N - 1) begin m_dark = 1; m_pl = 1; m_sl++; end
      else m_pos++;
    end else if (pr && !pl) begin
      if (m_pos == 0) begin m_dark = 1; m_pr = 1; m_sr++; end
      else m_pos--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_l = 0; in_r = 0; cpu_en = 0; cpu_thresh = '0;
    do_reset(2);
    checks++;
    if (field !== CENTER_F) begin
      failures++; $display("FAIL reset_field got=%b exp=%b", field, CENTER_F);
    end
    checks++;
    if (score_l !== 3'd0 || score_r !== 3'd0) begin
      failures++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", score_l, score_r);
    end
    checks++;
    if (match_over !== 1'b0 || winner !== 1'b0) begin
      failures++; $display("FAIL reset_match got=%b/%b exp=0/0", match_over, winner);
    end
    checks++;
    if (point_l !== 1'b0 || point_r !== 1'b0) begin
      failures++; $display("FAIL reset_points got=%b/%b exp=0/0", point_l, point_r);
    end
    tick();
    checks++;
    if (field !== m_field()) begin
      failures++; $display("FAIL reset_idle got=%b exp=%b", field, m_field());
    end
  endtask

  task automatic test_hold();
    in_l = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (field !== m_field()) begin
        failures++; $display("FAIL hold_cycle%0d got=%b exp=%b", i, field, m_field());
      end
    end
    in_l = 0;
    tick();
    checks++;
    if (field !== 9'b000100000) begin
      failures++; $display("FAIL hold_single_shift got=%b exp=%b", field, 9'b000100000);
    end
  endtask

  task automatic test_walk_left();
    logic [N-1:0] one;
    logic [N-1:0] exp;
    one = 1;
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      in_l = 1;
      tick();
      in_l = 0;
      exp = (i < 4) ? (one << (C + 1 + i)) : '0;
      checks++;
      if (field !== exp) begin
        failures++; $display("FAIL walk_press%0d got=%b exp=%b", i, field, exp);
      end
      if (i < 4) tick();
    end
    checks++;
    if (point_l !== 1'b1 || score_l !== 3'd1 || point_r !== 1'b0) begin
      failures++;
      $display("FAIL walk_point got=pl%b sl%0d pr%b exp=pl1 sl1 pr0", point_l, score_l, point_r);
    end
    tick();
    checks++;
    if (field !== CENTER_F || point_l !== 1'b0) begin
      failures++; $display("FAIL walk_recentre got=%b pl%b exp=%b pl0", field, point_l, CENTER_F);
    end
  endtask

  task automatic test_cancel();
    in_l = 1; in_r = 1;
    tick();
    checks++;
    if (field !== CENTER_F || point_l !== 1'b0 || point_r !== 1'b0) begin
      failures++; $display("FAIL cancel got=%b pl%b pr%b exp=%b", field, point_l, point_r, CENTER_F);
    end
    in_l = 0; in_r = 0;
    tick();
  endtask

  task automatic test_right_win();
    int budget;
    do_reset(1);
    budget = 200;
    while (!m_over && budget > 0) begin
      in_r = 1;
      tick();
      checks++;
      if ({field, score_r, point_r} !== {m_field(), SW'(m_sr), m_pr}) begin
        failures++;
        $display("FAIL rwin_press got=%b/%0d/%b exp=%b/%0d/%b",
                 field, score_r, point_r, m_field(), m_sr, m_pr);
      end
      in_r = 0;
      tick();
      checks++;
      if ({field, score_r, point_r} !== {m_field(), SW'(m_sr), m_pr}) begin
        failures++;
        $display("FAIL rwin_release got=%b/%0d/%b exp=%b/%0d/%b",
                 field, score_r, point_r, m_field(), m_sr, m_pr);
      end
      budget--;
    end
    checks++;
    if (match_over !== 1'b1 || winner !== 1'b1 || score_r !== 3'd7 ||
        field !== '0 || score_l !== 3'd0) begin
      failures++;
      $display("FAIL rwin_over got=mo%b w%b sr%0d sl%0d f%b exp=mo1 w1 sr7 sl0 f0",
               match_over, winner, score_r, score_l, field);
    end
    for (int i = 0; i < 10; i++) begin
      in_l = ($urandom_range(0, 1) == 1);
      in_r = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if ({match_over, winner, score_l, score_r, field, point_l, point_r} !==
          {1'b1, 1'b1, 3'd0, 3'd7, 9'd0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL rwin_hold%0d got=mo%b w%b sl%0d sr%0d f%b", i,
                 match_over, winner, score_l, score_r, field);
      end
    end
    in_l = 0; in_r = 0;
    do_reset(1);
    checks++;
    if (field !== CENTER_F || score_r !== 3'd0 || match_over !== 1'b0) begin
      failures++;
      $display("FAIL rwin_reset got=%b sr%0d mo%b exp=%b sr0 mo0", field, score_r, match_over, CENTER_F);
    end
  endtask

  task automatic test_cpu_idle();
    do_reset(1);
    cpu_en = 1; cpu_thresh = '0; in_l = 0;
    for (int i = 0; i < 500; i++) begin
      in_r = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if (field !== CENTER_F) begin
        failures++; $display("FAIL cpu_idle cyc%0d got=%b exp=%b", i, field, CENTER_F);
      end
    end
    in_r = 0;
  endtask

  task automatic test_lfsr();
    int exp_seq[3] = '{1, 3, 7};
    cpu_en = 1; cpu_thresh = '0;
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (int'(dut.lfsr_q) !== exp_seq[i] || m_lfsr != exp_seq[i]) begin
        failures++;
        $display("FAIL lfsr_cyc%0d got=%h exp=%h", i + 1, dut.lfsr_q, exp_seq[i]);
      end
    end
  endtask

  task automatic test_cpu_thresh();
    bit moved;
    moved = 0;
    cpu_thresh = 10'h200;
    for (int i = 0; i < 100 && !moved; i++) begin
      tick();
      checks++;
      if (field !== m_field()) begin
        failures++; $display("FAIL cpu_thresh_model got=%b exp=%b", field, m_field());
      end
      if (field !== CENTER_F) moved = 1;
    end
    checks++;
    if (field !== 9'b000001000) begin
      failures++; $display("FAIL cpu_thresh_move got=%b exp=%b", field, 9'b000001000);
    end
  endtask

  task automatic test_reset_in_point();
    cpu_en = 0; in_r = 0;
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      in_l = 1; tick();
      in_l = 0;
      if (i < 4) tick();
    end
    checks++;
    if (point_l !== 1'b1 || score_l !== 3'd1) begin
      failures++; $display("FAIL rip_setup got=pl%b sl%0d exp=pl1 sl1", point_l, score_l);
    end
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (score_l !== 3'd0 || point_l !== 1'b0 || field !== CENTER_F) begin
      failures++;
      $display("FAIL rip_reset got=sl%0d pl%b f%b exp=sl0 pl0 f%b", score_l, point_l, field, CENTER_F);
    end
    tick();
    checks++;
    if (score_l !== 3'd0 || point_l !== 1'b0 || match_over !== 1'b0) begin
      failures++;
      $display("FAIL rip_after got=sl%0d pl%b mo%b exp=sl0 pl0 mo0", score_l, point_l, match_over);
    end
  endtask

  task automatic test_random();
    logic [18:0] got;
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 1) in_l = ~in_l;
      if ($urandom_range(0, 1) == 1) in_r = ~in_r;
      if ($urandom_range(0, 199) == 0) cpu_en = ~cpu_en;
      if ($urandom_range(0, 49) == 0) cpu_thresh = LW'($urandom);
      reset = ($urandom_range(0, 599) == 0);
      tick();
      got = {field, score_l, score_r, point_l, point_r, match_over, winner};
      checks++;
      if (got !== m_vec()) begin
        failures++;
        $display("FAIL random cyc%0d got=%b exp=%b (field,sl,sr,pl,pr,mo,w)", i, got, m_vec());
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; in_l = 0; in_r = 0; cpu_en = 0; cpu_thresh = '0;
    test_reset();
    test_hold();
    test_walk_left();
    test_cancel();
    test_right_win();
    test_cpu_idle();
    test_lfsr();
    test_cpu_thresh();
    test_reset_in_point();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
